// File: rtl/fibo_sched_pkg.sv
// Shared types for the Fibonacci job scheduler: response status codes,
// controller states and the queued job record.
package fibo_sched_pkg;

   localparam int DATA_W  = 64;
   localparam int ORDER_W = 16;

   typedef enum logic [1:0] {
      ST_OK       = 2'd0,
      ST_OVERFLOW = 2'd1,
      ST_BADREQ   = 2'd2,
      ST_TIMEOUT  = 2'd3
   } status_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SETTLE = 3'd2,
      WAIT   = 3'd3,
      RESP   = 3'd4
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0]  seed;
      logic [ORDER_W-1:0] order;
   } job_t;

   // A zero seed or zero order never produces a meaningful term.
   function automatic logic is_bad_job(job_t job);
      return (job.seed == '0) || (job.order == '0);
   endfunction

endpackage

// File: rtl/fibo_req_fifo.sv
// Small job FIFO in front of the scheduler FSM; ready is a registered
// not-full flag so the upstream handshake has no combinational path.
module fibo_req_fifo
   import fibo_sched_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  job_t push_data,
   input  logic pop,
   output job_t pop_data,
   output logic empty,
   output logic ready
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

   job_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic [PTR_W:0]   count_next;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign do_push  = push && (!full || pop);
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_comb begin
      count_next = count;
      if (do_push && !do_pop) begin
         count_next = count + 1'b1;
      end else if (!do_push && do_pop) begin
         count_next = count - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ready  <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_next;
         ready <= (count_next != FULL_COUNT);
      end
   end

   // Storage needs no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fibo_job_scheduler.sv
// Request stage for the Fibonacci generator: queues jobs, screens bad ones,
// runs each valid job through the generator and returns in-order responses.
//
// state  | meaning
// IDLE   | waiting for a queued job; pops and screens it
// LOAD   | genLoad high for one cycle
// SETTLE | generator's registered done/carry still show the previous job
// WAIT   | watching done/carry, watchdog counting
// RESP   | response held until accepted
module fibo_job_scheduler
   import fibo_sched_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_W,
   parameter int ORDER_WIDTH    = ORDER_W,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 70000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   reqValid,
   output logic                   reqReady,
   input  logic [DATA_WIDTH-1:0]  reqData,
   input  logic [ORDER_WIDTH-1:0] reqOrder,
   output logic                   genLoad,
   output logic [DATA_WIDTH-1:0]  genData,
   output logic [ORDER_WIDTH-1:0] genOrder,
   input  logic [DATA_WIDTH-1:0]  genResult,
   input  logic                   genCarry,
   input  logic                   genDone,
   output logic                   respValid,
   input  logic                   respReady,
   output logic [DATA_WIDTH-1:0]  respResult,
   output logic [1:0]             respStatus
);

   localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   state_t          state;
   job_t            push_job;
   job_t            head;
   logic            fifo_empty;
   logic            pop;
   logic [WD_W-1:0] wd;

   assign push_job = '{seed: reqData, order: reqOrder};
   assign pop      = (state == IDLE) && !fifo_empty;

   fibo_req_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (reqValid && reqReady),
      .push_data (push_job),
      .pop       (pop),
      .pop_data  (head),
      .empty     (fifo_empty),
      .ready     (reqReady)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         genLoad    <= 1'b0;
         genData    <= '0;
         genOrder   <= '0;
         respValid  <= 1'b0;
         respResult <= '0;
         respStatus <= ST_OK;
         wd         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  if (is_bad_job(head)) begin
                     respValid  <= 1'b1;
                     respResult <= '0;
                     respStatus <= ST_BADREQ;
                     state      <= RESP;
                  end else begin
                     genData  <= head.seed;
                     genOrder <= head.order;
                     genLoad  <= 1'b1;
                     state    <= LOAD;
                  end
               end
            end
            LOAD: begin
               genLoad <= 1'b0;
               state   <= SETTLE;
            end
            SETTLE: begin
               wd    <= '0;
               state <= WAIT;
            end
            WAIT: begin
               wd <= wd + 1'b1;
               // done outranks carry, carry outranks the watchdog
               if (genDone) begin
                  respValid  <= 1'b1;
                  respResult <= genResult;
                  respStatus <= ST_OK;
                  state      <= RESP;
               end else if (genCarry) begin
                  respValid  <= 1'b1;
                  respResult <= '1;
                  respStatus <= ST_OVERFLOW;
                  state      <= RESP;
               end else if (wd == WD_LAST) begin
                  respValid  <= 1'b1;
                  respResult <= '0;
                  respStatus <= ST_TIMEOUT;
                  state      <= RESP;
               end
            end
            RESP: begin
               if (respReady) begin
                  respValid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fibo_job_scheduler.sv
// Scoreboard bench: a behavioural generator feeds the main scheduler, a
// stalled generator feeds a short-watchdog copy for the timeout case.
module tb_fibo_job_scheduler;

   typedef struct packed {
      logic [63:0] result;
      logic [1:0]  status;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        reqValid, reqReady, genLoad, genCarry, genDone;
   logic        respValid, respReady;
   logic [63:0] reqData, genData, genResult, respResult;
   logic [15:0] reqOrder, genOrder;
   logic [1:0]  respStatus;

   logic        reqValid2, reqReady2, genLoad2, respValid2;
   logic [63:0] reqData2, genData2, respResult2;
   logic [15:0] reqOrder2, genOrder2;
   logic [1:0]  respStatus2;

   int   vectors = 0;
   int   miscompares = 0;
   exp_t exp_q[$];

   int          loads = 0;
   int          bad_loads = 0;
   int          unstable = 0;
   logic [63:0] held_d = '0;
   logic [15:0] held_o = '0;

   fibo_job_scheduler dut (
      .clk(clk), .reset(reset),
      .reqValid(reqValid), .reqReady(reqReady), .reqData(reqData), .reqOrder(reqOrder),
      .genLoad(genLoad), .genData(genData), .genOrder(genOrder),
      .genResult(genResult), .genCarry(genCarry), .genDone(genDone),
      .respValid(respValid), .respReady(respReady),
      .respResult(respResult), .respStatus(respStatus)
   );

   fibo_job_scheduler #(.TIMEOUT_CYCLES(8)) dut_to (
      .clk(clk), .reset(reset),
      .reqValid(reqValid2), .reqReady(reqReady2), .reqData(reqData2), .reqOrder(reqOrder2),
      .genLoad(genLoad2), .genData(genData2), .genOrder(genOrder2),
      .genResult(64'h1234_5678_9ABC_DEF0), .genCarry(1'b0), .genDone(1'b0),
      .respValid(respValid2), .respReady(1'b1),
      .respResult(respResult2), .respStatus(respStatus2)
   );

   // Behavioural generator: a=b=seed, then order-1 steps of (a,b)<=(b,a+b).
   logic [63:0] g_a, g_b;
   logic [15:0] g_cnt;
   logic [64:0] g_sum;
   assign g_sum = {1'b0, g_a} + {1'b0, g_b};

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         g_a <= '0; g_b <= '0; g_cnt <= '0;
         genDone <= 1'b0; genCarry <= 1'b0; genResult <= '0;
      end else if (genLoad) begin
         g_a <= genData; g_b <= genData; g_cnt <= genOrder;
         genDone <= 1'b0; genCarry <= 1'b0;
      end else if (!genDone && !genCarry) begin
         if (g_cnt <= 16'd1) begin
            genDone   <= 1'b1;
            genResult <= g_b;
         end else if (g_sum[64]) begin
            genCarry <= 1'b1;
         end else begin
            g_a   <= g_b;
            g_b   <= g_sum[63:0];
            g_cnt <= g_cnt - 16'd1;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] s, input logic [15:0] o, input int limit,
                       output bit ok);
      int n = 0;
      reqValid = 1'b1; reqData = s; reqOrder = o;
      while (!reqReady && n < limit) begin
         tick();
         n++;
      end
      ok = reqReady;
      if (ok) tick();
      reqValid = 1'b0;
   endtask

   task automatic expect_resp(input logic [63:0] r, input logic [1:0] st);
      exp_q.push_back('{result: r, status: st});
   endtask

   task automatic drain(input int limit);
      int n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("pending_responses", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   // Response monitor / scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && respValid && respReady) begin
            if (exp_q.size() == 0) begin
               check("unexpected_resp_status", {62'd0, respStatus}, 64'hFF);
            end else begin
               e = exp_q.pop_front();
               check("resp_result", respResult, e.result);
               check("resp_status", {62'd0, respStatus}, {62'd0, e.status});
            end
         end
      end
   end

   // Generator-side watcher: load count, screened jobs, operand stability.
   initial begin
      bit tracking = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            tracking = 1'b0;
         end else begin
            if (genLoad) begin
               loads++;
               tracking = 1'b1;
               held_d = genData;
               held_o = genOrder;
               if (genData == '0 || genOrder == '0) bad_loads++;
            end else if (tracking && (genData != held_d || genOrder != held_o)) begin
               unstable++;
            end
            if (respValid) tracking = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running, required completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "global timeout");
   end

   initial begin
      bit ok;
      int l0, u0, n, m, acc;

      reset = 1'b1; reqValid = 1'b0; reqData = '0; reqOrder = '0; respReady = 1'b1;
      reqValid2 = 1'b0; reqData2 = '0; reqOrder2 = '0;
      tick(); tick();
      check("rst_reqReady", {63'd0, reqReady}, 64'd0);
      check("rst_genLoad", {63'd0, genLoad}, 64'd0);
      check("rst_genData", genData, 64'd0);
      check("rst_respValid", {63'd0, respValid}, 64'd0);
      check("rst_respResult", respResult, 64'd0);
      reset = 1'b0;
      tick();
      check("post_rst_reqReady", {63'd0, reqReady}, 64'd1);

      // 1: minimal job
      l0 = loads;
      expect_resp(64'd1, 2'd0);
      send(64'd1, 16'd1, 20, ok);
      drain(200);
      check("t1_loads", 64'(loads - l0), 64'd1);

      // 2: seed 1 order 10, operands held
      l0 = loads; u0 = unstable;
      expect_resp(64'd89, 2'd0);
      send(64'd1, 16'd10, 20, ok);
      drain(200);
      check("t2_loads", 64'(loads - l0), 64'd1);
      check("t2_genData", held_d, 64'd1);
      check("t2_genOrder", {48'd0, held_o}, 64'd10);
      check("t2_stable", 64'(unstable - u0), 64'd0);

      // 3: overflow
      expect_resp(64'hFFFF_FFFF_FFFF_FFFF, 2'd1);
      send(64'd1, 16'd100, 20, ok);
      drain(400);

      // 4: back-to-back with two screened jobs
      l0 = loads;
      expect_resp(64'd0, 2'd2); send(64'd0, 16'd5, 20, ok);
      expect_resp(64'd0, 2'd2); send(64'd7, 16'd0, 20, ok);
      expect_resp(64'd6, 2'd0); send(64'd2, 16'd3, 20, ok);
      expect_resp(64'd8, 2'd0); send(64'd1, 16'd5, 20, ok);
      drain(400);
      check("t4_loads", 64'(loads - l0), 64'd2);
      check("t4_bad_loads", 64'(bad_loads), 64'd0);

      // 5: watchdog on the stalled generator, TIMEOUT_CYCLES=8
      check("t5_reqReady", {63'd0, reqReady2}, 64'd1);
      reqValid2 = 1'b1; reqData2 = 64'd5; reqOrder2 = 16'd7;
      tick();
      reqValid2 = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!genLoad2 && n < 20);
      check("t5_load_seen", {63'd0, genLoad2}, 64'd1);
      m = 0;
      do begin
         @(negedge clk);
         m++;
      end while (!respValid2 && m < 50);
      check("t5_latency", 64'(m), 64'd10);
      check("t5_status", {62'd0, respStatus2}, 64'd3);
      check("t5_result", respResult2, 64'd0);
      tick(); tick();

      // 6: backpressure, then reset mid-WAIT
      respReady = 1'b0;
      expect_resp(64'd3, 2'd0);
      acc = 0;
      send(64'd1, 16'd3, 20, ok);
      if (ok) acc++;
      for (int i = 0; i < 5; i++) begin
         send(64'd1, 16'd40, 4, ok);
         if (ok) acc++;
      end
      check("t6_accepted", 64'(acc), 64'd5);
      check("t6_reqReady_low", {63'd0, reqReady}, 64'd0);
      repeat (6) tick();
      check("t6_stalled_valid", {63'd0, respValid}, 64'd1);
      respReady = 1'b1;
      repeat (10) tick();
      check("t6_first_resp_done", 64'(exp_q.size()), 64'd0);
      check("t6_in_wait_no_resp", {63'd0, respValid}, 64'd0);
      reset = 1'b1;
      #1;
      check("t6_rst_genLoad", {63'd0, genLoad}, 64'd0);
      check("t6_rst_genData", genData, 64'd0);
      check("t6_rst_genOrder", {48'd0, genOrder}, 64'd0);
      check("t6_rst_reqReady", {63'd0, reqReady}, 64'd0);
      check("t6_rst_respValid", {63'd0, respValid}, 64'd0);
      check("t6_rst_respStatus", {62'd0, respStatus}, 64'd0);
      tick(); tick();
      reset = 1'b0;
      tick();
      check("t6_rel_reqReady", {63'd0, reqReady}, 64'd1);
      l0 = loads;
      repeat (30) tick();
      check("t6_no_stale_load", 64'(loads - l0), 64'd0);
      check("t6_no_stale_valid", {63'd0, respValid}, 64'd0);
      expect_resp(64'd6, 2'd0);
      send(64'd3, 16'd2, 20, ok);
      drain(200);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
